// File: rtl/cricket_pkg.sv
// Shared types and outcome-code boundaries
// for the two-innings scoring engine.
package cricket_pkg;

  typedef enum logic [1:0] {
    INN1  = 2'd0,
    BREAK = 2'd1,
    INN2  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE  = 2'b00,
    RES_FIRST = 2'b01,
    RES_CHASE = 2'b10,
    RES_TIE   = 2'b11
  } result_t;

  localparam logic [3:0] OC_DOT_MAX = 4'd2;
  localparam logic [3:0] OC_ONE_MAX = 4'd6;
  localparam logic [3:0] OC_TWO_MAX = 4'd9;
  localparam logic [3:0] OC_THREE   = 4'd10;
  localparam logic [3:0] OC_FOUR    = 4'd11;
  localparam logic [3:0] OC_SIX     = 4'd12;
  localparam logic [3:0] OC_WIDE    = 4'd13;
  localparam logic [3:0] OC_NOBALL  = 4'd14;
  localparam logic [3:0] OC_WICKET  = 4'd15;

endpackage

// File: rtl/ball_decoder.sv
// Outcome code -> run value, legal flag, wicket.
// EXTRAS_EN enables wide / no-ball decoding.
module ball_decoder
  import cricket_pkg::*;
(
  input  logic [3:0] outcome,
  output logic [2:0] run_val,
  output logic       legal,
  output logic       wicket
);

  // Range decode of the random outcome code
  always_comb begin
    run_val = 3'd0;
    legal   = 1'b1;
    wicket  = 1'b0;
    unique case (1'b1)
      (outcome <= OC_DOT_MAX):
        run_val = 3'd0;
      (outcome > OC_DOT_MAX &&
       outcome <= OC_ONE_MAX):
        run_val = 3'd1;
      (outcome > OC_ONE_MAX &&
       outcome <= OC_TWO_MAX):
        run_val = 3'd2;
      (outcome == OC_THREE):
        run_val = 3'd3;
      (outcome == OC_FOUR):
        run_val = 3'd4;
      (outcome == OC_SIX):
        run_val = 3'd6;
      (outcome == OC_WIDE),
      (outcome == OC_NOBALL): begin
`ifdef EXTRAS_EN
        run_val = 3'd1;
        legal   = 1'b0;
`else
        run_val = 3'd0;
`endif
      end
      (outcome == OC_WICKET):
        wicket = 1'b1;
    endcase
  end

endmodule

// File: rtl/innings_scorer.sv
// Two-innings T20 scorer: FSM, counters, winner.
// EXTRAS_EN (in ball_decoder) enables wides/no-balls.
module innings_scorer
  import cricket_pkg::*;
#(
  parameter int MAX_OVERS      = 20,
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_WICKETS    = 10,
  parameter int RUN_W          = 8
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             delivery,
  input  logic [3:0]       outcome,
  input  logic             next_innings,
  output logic [RUN_W-1:0] runs,
  output logic [3:0]       wickets,
  output logic [2:0]       balls,
  output logic [5:0]       overs,
  output logic [RUN_W:0]   target,
  output logic             innings,
  output logic             inning_over,
  output logic             game_over,
  output logic [1:0]       result
);

  localparam logic [2:0] BPO_M1 =
    3'(BALLS_PER_OVER - 1);
  localparam logic [3:0] WK_LIM =
    4'(MAX_WICKETS);
  localparam logic [5:0] OV_LIM =
    6'(MAX_OVERS);
  localparam logic [RUN_W:0] ONE = 1;

  state_t           state;
  logic             rst_hold;
  logic [2:0]       run_val;
  logic             legal;
  logic             wkt;
  logic [RUN_W:0]   run_sum;
  logic [RUN_W-1:0] runs_n;
  logic [RUN_W:0]   runs_x;
  logic [3:0]       wk_n;
  logic [2:0]       balls_n;
  logic [5:0]       overs_n;
  logic             over_end;
  logic             inn_end;
  logic             chased;
  logic             tied;

  ball_decoder u_dec (
    .outcome (outcome),
    .run_val (run_val),
    .legal   (legal),
    .wicket  (wkt)
  );

  // Post-ball counter values for the sampled delivery
  always_comb begin
    run_sum  = {1'b0, runs} +
               {{(RUN_W-2){1'b0}}, run_val};
    runs_n   = run_sum[RUN_W] ? '1
                              : run_sum[RUN_W-1:0];
    runs_x   = {1'b0, runs_n};
    wk_n     = wickets + {3'b000, wkt};
    over_end = legal && (balls == BPO_M1);
    balls_n  = balls;
    if (legal)
      balls_n = over_end ? 3'd0 : balls + 3'd1;
    overs_n  = overs + {5'b0, over_end};
    inn_end  = (wk_n == WK_LIM) ||
               (overs_n == OV_LIM);
    chased   = runs_x >= target;
    tied     = runs_x == (target - ONE);
  end

  // Hold the core idle for one edge after reset release
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) rst_hold <= 1'b1;
    else       rst_hold <= 1'b0;
  end

  // Innings sequencing, scoring and winner decision
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state       <= INN1;
      runs        <= '0;
      wickets     <= '0;
      balls       <= '0;
      overs       <= '0;
      target      <= '0;
      innings     <= 1'b0;
      inning_over <= 1'b0;
      game_over   <= 1'b0;
      result      <= RES_NONE;
    end else if (!rst_hold) begin
      unique case (state)
        INN1, INN2: begin
          if (delivery) begin
            runs    <= runs_n;
            wickets <= wk_n;
            balls   <= balls_n;
            overs   <= overs_n;
            if (state == INN1) begin
              if (inn_end) begin
                target      <= runs_x + ONE;
                state       <= BREAK;
                inning_over <= 1'b1;
              end
            end else if (chased || inn_end) begin
              state       <= DONE;
              inning_over <= 1'b1;
              game_over   <= 1'b1;
              if (chased)    result <= RES_CHASE;
              else if (tied) result <= RES_TIE;
              else           result <= RES_FIRST;
            end
          end
        end
        BREAK: begin
          if (next_innings) begin
            runs        <= '0;
            wickets     <= '0;
            balls       <= '0;
            overs       <= '0;
            innings     <= 1'b1;
            inning_over <= 1'b0;
            state       <= INN2;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_innings_scorer.sv
// Vector-table bench with an expected-value queue
// for innings_scorer (1 over, 6 balls, 2 wickets).
module tb_innings_scorer;

  logic       clk_fpga = 1'b0;
  logic       reset = 1'b0;
  logic       delivery = 1'b0;
  logic       next_innings = 1'b0;
  logic [3:0] outcome = 4'd0;
  logic [7:0] runs;
  logic [3:0] wickets;
  logic [2:0] balls;
  logic [5:0] overs;
  logic [8:0] target;
  logic       innings;
  logic       inning_over;
  logic       game_over;
  logic [1:0] result;

  logic       s_rst = 1'b0;
  logic       s_dlv = 1'b0;
  logic [3:0] s_oc = 4'd0;
  logic [2:0] s_runs;
  logic [3:0] s_wk;
  logic [2:0] s_balls;
  logic [5:0] s_overs;
  logic [3:0] s_tgt;
  logic       s_inn;
  logic       s_io;
  logic       s_go;
  logic [1:0] s_res;

  innings_scorer #(
    .MAX_OVERS(1), .BALLS_PER_OVER(6),
    .MAX_WICKETS(2), .RUN_W(8)
  ) u_dut (
    .clk_fpga     (clk_fpga),
    .reset        (reset),
    .delivery     (delivery),
    .outcome      (outcome),
    .next_innings (next_innings),
    .runs         (runs),
    .wickets      (wickets),
    .balls        (balls),
    .overs        (overs),
    .target       (target),
    .innings      (innings),
    .inning_over  (inning_over),
    .game_over    (game_over),
    .result       (result)
  );

  innings_scorer #(
    .MAX_OVERS(1), .BALLS_PER_OVER(6),
    .MAX_WICKETS(2), .RUN_W(3)
  ) u_sat (
    .clk_fpga     (clk_fpga),
    .reset        (s_rst),
    .delivery     (s_dlv),
    .outcome      (s_oc),
    .next_innings (1'b0),
    .runs         (s_runs),
    .wickets      (s_wk),
    .balls        (s_balls),
    .overs        (s_overs),
    .target       (s_tgt),
    .innings      (s_inn),
    .inning_over  (s_io),
    .game_over    (s_go),
    .result       (s_res)
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct packed {
    logic [7:0] runs;
    logic [3:0] wk;
    logic [2:0] balls;
    logic [5:0] overs;
    logic [8:0] tgt;
    logic       inn;
    logic       io;
    logic       go;
    logic [1:0] res;
  } exp_t;

  typedef struct {
    string      name;
    bit         rst;
    bit         dlv;
    bit         nxt;
    logic [3:0] oc;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(
    input string nm, input bit rs,
    input bit d, input bit n, input int oc,
    input int r, input int w, input int b,
    input int o, input int t, input int inn,
    input int io, input int go, input int res);
    vec_t v;
    v.name    = nm;
    v.rst     = rs;
    v.dlv     = d;
    v.nxt     = n;
    v.oc      = 4'(oc);
    v.e.runs  = 8'(r);
    v.e.wk    = 4'(w);
    v.e.balls = 3'(b);
    v.e.overs = 6'(o);
    v.e.tgt   = 9'(t);
    v.e.inn   = 1'(inn);
    v.e.io    = 1'(io);
    v.e.go    = 1'(go);
    v.e.res   = 2'(res);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm,
    input string f, input int got,
    input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d, want %0d",
               nm, f, got, want);
    end
  endtask

  task automatic check_dut(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got empty queue, want entry",
               nm);
    end else begin
      e = sb.pop_front();
      chk(nm, "runs", runs, e.runs);
      chk(nm, "wickets", wickets, e.wk);
      chk(nm, "balls", balls, e.balls);
      chk(nm, "overs", overs, e.overs);
      chk(nm, "target", target, e.tgt);
      chk(nm, "innings", innings, e.inn);
      chk(nm, "inning_over", inning_over, e.io);
      chk(nm, "game_over", game_over, e.go);
      chk(nm, "result", result, e.res);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // six singles end innings 1; both strobes in BREAK
    add("a_ign", 1, 1, 0, 3, 0,0,0,0,0,0,0,0,0);
    for (int i = 1; i <= 5; i++)
      add($sformatf("a%0d", i), 0, 1, 0, 3,
          i,0,i,0,0,0,0,0,0);
    add("a6", 0, 1, 0, 3, 6,0,0,1,7,0,1,0,0);
    add("a_brk_dlv", 0, 1, 0, 12, 6,0,0,1,7,0,1,0,0);
    add("a_both", 0, 1, 1, 12, 0,0,0,0,7,1,0,0,0);
    add("a_four", 0, 1, 0, 11, 4,0,1,0,7,1,0,0,0);
    add("a_one", 0, 1, 0, 3, 5,0,2,0,7,1,0,0,0);
    // mid-INN2 reset, then wickets end innings 1
    add("b_ign", 1, 1, 0, 12, 0,0,0,0,0,0,0,0,0);
    add("b_six", 0, 1, 0, 12, 6,0,1,0,0,0,0,0,0);
    add("b_w1", 0, 1, 0, 15, 6,1,2,0,0,0,0,0,0);
    add("b_w2", 0, 1, 0, 15, 6,2,3,0,7,0,1,0,0);
    add("b_next", 0, 0, 1, 0, 0,0,0,0,7,1,0,0,0);
    add("b_six2", 0, 1, 0, 12, 6,0,1,0,7,1,0,0,0);
    add("b_win", 0, 1, 0, 3, 7,0,2,0,7,1,1,1,2);
    add("b_dn_dlv", 0, 1, 0, 12, 7,0,2,0,7,1,1,1,2);
    add("b_dn_nxt", 0, 0, 1, 0, 7,0,2,0,7,1,1,1,2);
    // defended total: six dots in the chase
    add("c_idle", 1, 0, 0, 0, 0,0,0,0,0,0,0,0,0);
    add("c_nxt1", 0, 0, 1, 0, 0,0,0,0,0,0,0,0,0);
    for (int i = 1; i <= 5; i++)
      add($sformatf("c%0d", i), 0, 1, 0, 3,
          i,0,i,0,0,0,0,0,0);
    add("c6", 0, 1, 0, 3, 6,0,0,1,7,0,1,0,0);
    add("c_next", 0, 0, 1, 0, 0,0,0,0,7,1,0,0,0);
    for (int i = 1; i <= 5; i++)
      add($sformatf("c_d%0d", i), 0, 1, 0, 0,
          0,0,i,0,7,1,0,0,0);
    add("c_d6", 0, 1, 0, 0, 0,0,0,1,7,1,1,1,1);
    // tie: six singles in the chase
    add("t_idle", 1, 0, 0, 0, 0,0,0,0,0,0,0,0,0);
    for (int i = 1; i <= 5; i++)
      add($sformatf("t%0d", i), 0, 1, 0, 3,
          i,0,i,0,0,0,0,0,0);
    add("t6", 0, 1, 0, 3, 6,0,0,1,7,0,1,0,0);
    add("t_next", 0, 0, 1, 0, 0,0,0,0,7,1,0,0,0);
    for (int i = 1; i <= 5; i++)
      add($sformatf("t_s%0d", i), 0, 1, 0, 3,
          i,0,i,0,7,1,0,0,0);
    add("t_s6", 0, 1, 0, 3, 6,0,0,1,7,1,1,1,3);
    // code 13 three times, then six dots
    add("e_idle", 1, 0, 0, 0, 0,0,0,0,0,0,0,0,0);
`ifdef EXTRAS_EN
    for (int i = 1; i <= 3; i++)
      add($sformatf("e_x%0d", i), 0, 1, 0, 13,
          i,0,0,0,0,0,0,0,0);
    for (int i = 1; i <= 5; i++)
      add($sformatf("e_d%0d", i), 0, 1, 0, 0,
          3,0,i,0,0,0,0,0,0);
    add("e_d6", 0, 1, 0, 0, 3,0,0,1,4,0,1,0,0);
`else
    for (int i = 1; i <= 3; i++)
      add($sformatf("e_x%0d", i), 0, 1, 0, 13,
          0,0,i,0,0,0,0,0,0);
    for (int i = 1; i <= 2; i++)
      add($sformatf("e_d%0d", i), 0, 1, 0, 0,
          0,0,3+i,0,0,0,0,0,0);
    for (int i = 3; i <= 6; i++)
      add($sformatf("e_d%0d", i), 0, 1, 0, 0,
          0,0,0,1,1,0,1,0,0);
`endif

    @(negedge clk_fpga);
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        #2;
        reset        = 1'b1;
        delivery     = 1'b0;
        next_innings = 1'b0;
        sb.push_back('0);
        #1;
        check_dut({tbl[i].name, "_rst"});
        @(negedge clk_fpga);
        reset = 1'b0;
      end
      delivery     = tbl[i].dlv;
      next_innings = tbl[i].nxt;
      outcome      = tbl[i].oc;
      sb.push_back(tbl[i].e);
      @(posedge clk_fpga);
      @(negedge clk_fpga);
      check_dut(tbl[i].name);
    end
    delivery     = 1'b0;
    next_innings = 1'b0;

    // 3-bit run counter saturates at 7
    #2 s_rst = 1'b1;
    #1 s_rst = 1'b0;
    @(negedge clk_fpga);
    chk("sat_rst", "runs", s_runs, 0);
    s_dlv = 1'b1;
    s_oc  = 4'd12;
    @(posedge clk_fpga);
    @(negedge clk_fpga);
    chk("sat1", "runs", s_runs, 6);
    @(posedge clk_fpga);
    @(negedge clk_fpga);
    chk("sat2", "runs", s_runs, 7);
    @(posedge clk_fpga);
    @(negedge clk_fpga);
    chk("sat3", "runs", s_runs, 7);
    chk("sat3", "balls", s_balls, 3);
    chk("sat3", "inning_over", s_io, 0);
    s_dlv = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
